// File: rtl/font_char_sequencer_if.sv
// -----------------------------------------------------------------------------
// font_char_sequencer_if
//   Groups the two requester handshakes that feed font_char_sequencer.
//   Port 0 is the host requester, port 1 is the auto/demo requester.
//
//   Signals:
//     req0_valid / req0_char / req0_ready : host port handshake
//     req1_valid / req1_char / req1_ready : auto/demo port handshake
//
//   Modports:
//     master : requester side (drives valid/char, receives ready)
//     slave  : sequencer side (receives valid/char, drives ready)
// -----------------------------------------------------------------------------
interface font_char_sequencer_if;
  logic       req0_valid;
  logic [7:0] req0_char;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_char;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_char, req1_valid, req1_char,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_char, req1_valid, req1_char,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/font_char_sequencer.sv
// -----------------------------------------------------------------------------
// font_char_sequencer
//   Merges characters from two requesters (round-robin) into a shared FIFO and
//   presents them one at a time on ascii_value, changing only on frame_start
//   and holding each character for HOLD_FRAMES frames.
//
//   Parameters:
//     HOLD_FRAMES  : frames each character is held (1..255)
//     FIFO_DEPTH   : shared queue depth (power of two, 2..16)
//     DEFAULT_CHAR : ascii_value after reset
//
//   Ports:
//     clk          : system clock, rising edge
//     rst          : asynchronous active-high reset
//     frame_start  : one-cycle pulse at the start of each VGA frame
//     req          : requester handshakes (slave modport)
//     ascii_value  : registered character to the font renderer
//     char_strobe  : one-cycle pulse when ascii_value takes a new value
//     fifo_count   : current queue occupancy
//     busy         : high while holding a character or the queue is non-empty
//
//   Build option:
//     FONT_SEQ_PRINTABLE_FILTER_EN : when defined, characters outside
//       8'h20..8'h7E are replaced by 8'h3F ('?') at push time.
// -----------------------------------------------------------------------------
module font_char_sequencer #(
  parameter int unsigned HOLD_FRAMES  = 60,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  DEFAULT_CHAR = 8'h20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  font_char_sequencer_if.slave          req,
  output logic [7:0]                    ascii_value,
  output logic                          char_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned  PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned  CW          = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]   HOLD_RELOAD = 8'(HOLD_FRAMES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, next_state;
  logic [7:0]    hold_cnt, next_hold_cnt;
  logic [7:0]    next_ascii;
  logic          last_grant;   // 1 = port 1 was granted last
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          can_accept, grant0, grant1, push, pop;
  logic [7:0]    raw_char, push_char;

  // ---------------------------------------------------------------------------
  // Arbiter: grants come from registered count and last_grant only, so a pop
  // in the same cycle never frees a slot for a push.
  // ---------------------------------------------------------------------------
  assign can_accept = !rst && (fifo_count != FULL_COUNT);
  assign grant0     = can_accept && req.req0_valid && (!req.req1_valid || last_grant);
  assign grant1     = can_accept && req.req1_valid && (!req.req0_valid || !last_grant);
  assign req.req0_ready = grant0;
  assign req.req1_ready = grant1;
  assign push       = grant0 || grant1;
  assign raw_char   = grant0 ? req.req0_char : req.req1_char;

`ifdef FONT_SEQ_PRINTABLE_FILTER_EN
  assign push_char  = (raw_char >= 8'h20 && raw_char <= 8'h7E) ? raw_char : 8'h3F;
`else
  assign push_char  = raw_char;
`endif

  // ---------------------------------------------------------------------------
  // Display FSM, next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be
    // inferred when a path leaves it unassigned.
    next_state    = state;
    next_hold_cnt = hold_cnt;
    next_ascii    = ascii_value;
    pop           = 1'b0;
    if (frame_start) begin
      unique case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            pop           = 1'b1;
            next_ascii    = mem[rd_ptr];
            next_hold_cnt = HOLD_RELOAD;
            next_state    = HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt != 8'd0) begin
            next_hold_cnt = hold_cnt - 8'd1;
          end else if (fifo_count != '0) begin
            pop           = 1'b1;
            next_ascii    = mem[rd_ptr];
            next_hold_cnt = HOLD_RELOAD;
          end else begin
            next_state    = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, pointers, count and arbitration history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= 8'd0;
      ascii_value <= DEFAULT_CHAR;
      char_strobe <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      last_grant  <= 1'b1;
    end else begin
      state       <= next_state;
      hold_cnt    <= next_hold_cnt;
      ascii_value <= next_ascii;
      char_strobe <= pop;
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        last_grant <= grant1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count, so clearing the contents would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_char;
  end

  assign busy = (state == HOLD) || (fifo_count != '0);

endmodule

// File: tb/tb_font_char_sequencer.sv
// -----------------------------------------------------------------------------
// tb_font_char_sequencer
//   Directed bench for font_char_sequencer. dut0 uses HOLD_FRAMES = 2 for the
//   reset, single-char, round-robin, full-with-pop, flush and filter vectors;
//   dut1 uses HOLD_FRAMES = 1 for the wrap-around vector.
// -----------------------------------------------------------------------------
module tb_font_char_sequencer;

`ifdef FONT_SEQ_PRINTABLE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fs;
  logic [7:0] ascii0, ascii1;
  logic       strobe0, strobe1;
  logic [2:0] count0, count1;
  logic       busy0, busy1;

  always #5 clk = ~clk;

  font_char_sequencer_if bus0 ();
  font_char_sequencer_if bus1 ();

  font_char_sequencer #(.HOLD_FRAMES(2), .FIFO_DEPTH(4), .DEFAULT_CHAR(8'h20)) dut0 (
    .clk(clk), .rst(rst), .frame_start(fs), .req(bus0),
    .ascii_value(ascii0), .char_strobe(strobe0), .fifo_count(count0), .busy(busy0)
  );

  font_char_sequencer #(.HOLD_FRAMES(1), .FIFO_DEPTH(4), .DEFAULT_CHAR(8'h20)) dut1 (
    .clk(clk), .rst(rst), .frame_start(fs), .req(bus1),
    .ascii_value(ascii1), .char_strobe(strobe1), .fifo_count(count1), .busy(busy1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle frame_start pulse, sampled by exactly one edge.
  task automatic frame();
    fs = 1'b1;
    step();
    fs = 1'b0;
  endtask

  logic [7:0] wrap_chars [10];
  int         pi, di;
  logic       accept;

  initial begin
    rst             = 1'b1;
    fs              = 1'b0;
    bus0.req0_valid = 1'b1;
    bus0.req0_char  = 8'h34;
    bus0.req1_valid = 1'b0;
    bus0.req1_char  = 8'h00;
    bus1.req0_valid = 1'b0;
    bus1.req0_char  = 8'h00;
    bus1.req1_valid = 1'b0;
    bus1.req1_char  = 8'h00;

    // Reset held 50 cycles with port 0 requesting.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 25) begin
        check("rst_ascii0",  ascii0, 8'h20);
        check("rst_ascii1",  ascii1, 8'h20);
        check("rst_ready0",  bus0.req0_ready, 1'b0);
        check("rst_ready1",  bus0.req1_ready, 1'b0);
        check("rst_count",   count0, 3'd0);
        check("rst_busy",    busy0, 1'b0);
        check("rst_strobe",  strobe0, 1'b0);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("release_ready0", bus0.req0_ready, 1'b1);
    step();                           // '4' accepted here
    bus0.req0_valid = 1'b0;
    @(negedge clk);
    check("single_count", count0, 3'd1);
    check("single_busy",  busy0, 1'b1);
    repeat (3) step();

    // Single char display and hold for two frames.
    frame();
    @(negedge clk);
    check("single_ascii",  ascii0, 8'h34);
    check("single_strobe", strobe0, 1'b1);
    check("single_popcnt", count0, 3'd0);
    step();
    @(negedge clk);
    check("single_strobe_low", strobe0, 1'b0);
    frame();
    @(negedge clk);
    check("hold_busy", busy0, 1'b1);
    frame();
    @(negedge clk);
    check("idle_busy",  busy0, 1'b0);
    check("idle_ascii", ascii0, 8'h34);

    // Reset so last_grant returns to 1 and port 0 wins the first tie.
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Round-robin with both ports held valid.
    bus0.req0_valid = 1'b1;
    bus0.req0_char  = 8'h41;
    bus0.req1_valid = 1'b1;
    bus0.req1_char  = 8'h42;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_ready0", bus0.req0_ready, (k % 2) == 0);
      check("rr_ready1", bus0.req1_ready, (k % 2) == 1);
    end
    @(negedge clk);
    check("full_count",  count0, 3'd4);
    check("full_ready0", bus0.req0_ready, 1'b0);
    check("full_ready1", bus0.req1_ready, 1'b0);

    // Full with simultaneous pop: no push, count drops to 3.
    bus0.req1_valid = 1'b0;
    fs = 1'b1;
    #1;
    check("fullpop_ready0_before", bus0.req0_ready, 1'b0);
    @(posedge clk);
    #1 fs = 1'b0;
    @(negedge clk);
    check("fullpop_count",  count0, 3'd3);
    check("fullpop_ascii",  ascii0, 8'h41);
    check("fullpop_ready0", bus0.req0_ready, 1'b1);
    step();                           // re-push 'A'
    bus0.req0_valid = 1'b0;
    @(negedge clk);
    check("refill_count", count0, 3'd4);

    // Remaining queue order: B, A, B, A.
    frame(); frame();
    @(negedge clk);
    check("order_1", ascii0, 8'h42);
    frame(); frame();
    @(negedge clk);
    check("order_2", ascii0, 8'h41);
    frame(); frame();
    @(negedge clk);
    check("order_3", ascii0, 8'h42);
    frame(); frame();
    @(negedge clk);
    check("order_4", ascii0, 8'h41);

    // Asynchronous flush mid-operation, away from any clock edge.
    bus0.req0_valid = 1'b1;
    bus0.req0_char  = 8'h55;
    step();
    bus0.req0_valid = 1'b0;
    @(negedge clk);
    check("preflush_count", count0, 3'd1);
    rst = 1'b1;
    #1;
    check("flush_count", count0, 3'd0);
    check("flush_busy",  busy0, 1'b0);
    check("flush_ascii", ascii0, 8'h20);
    step();
    rst = 1'b0;

    // Filter: 0A on port 0, 80 on port 1 alone, 7E on port 0.
    bus0.req0_valid = 1'b1;
    bus0.req0_char  = 8'h0A;
    @(negedge clk);
    check("filt_ready0", bus0.req0_ready, 1'b1);
    step();
    bus0.req0_valid = 1'b0;
    bus0.req1_valid = 1'b1;
    bus0.req1_char  = 8'h80;
    @(negedge clk);
    check("filt_ready1", bus0.req1_ready, 1'b1);
    step();
    bus0.req1_valid = 1'b0;
    bus0.req0_valid = 1'b1;
    bus0.req0_char  = 8'h7E;
    step();
    bus0.req0_valid = 1'b0;
    @(negedge clk);
    check("filt_count", count0, 3'd3);
    frame();
    @(negedge clk);
    check("filt_0a", ascii0, FILTER ? 8'h3F : 8'h0A);
    frame(); frame();
    @(negedge clk);
    check("filt_80", ascii0, FILTER ? 8'h3F : 8'h80);
    frame(); frame();
    @(negedge clk);
    check("filt_7e", ascii0, 8'h7E);

    // Wrap-around: 10 chars through the 4-deep queue, HOLD_FRAMES = 1.
    for (int i = 0; i < 10; i++) wrap_chars[i] = 8'h61 + 8'(i);
    pi = 0;
    di = 0;
    step();
    for (int cyc = 0; cyc < 400 && di < 10; cyc++) begin
      bus1.req0_valid = (pi < 10);
      bus1.req0_char  = (pi < 10) ? wrap_chars[pi] : 8'h00;
      fs              = (cyc % 3) == 0;
      @(negedge clk);
      if (strobe1) begin
        check("wrap_char", ascii1, wrap_chars[di]);
        di++;
      end
      accept = bus1.req0_ready;
      step();
      if (accept) pi++;
    end
    fs = 1'b0;
    bus1.req0_valid = 1'b0;
    check("wrap_pushed",    pi, 10);
    check("wrap_displayed", di, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
